// File: rtl/scs8hd_dlytap_ctrl.sv
// Tap-select sequencer for a scs8hd_clkdlybuf4s25_2 delay line.
// Takes a target tap over REQ/ACK and walks SEL one tap at a time, holding
// SETTLE idle cycles after each step so the delayed clock never jumps by
// more than one buffer delay per update.
module scs8hd_dlytap_ctrl #(
   parameter int NTAPS   = 16,
   parameter int TAPW    = 4,
   parameter int SETTLE  = 3,
   parameter int RST_TAP = 0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            REQ,
   input  logic [TAPW-1:0] TGT,
   output logic            ACK,
   output logic            BUSY,
   output logic [TAPW-1:0] SEL,
   output logic            CLAMP
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMP,
      S_STEP,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [TAPW-1:0] MAX_TAP = TAPW'(NTAPS - 1);
   localparam logic [TAPW-1:0] RST_SEL = TAPW'(RST_TAP);
   localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);

   state_t          state_q, state_d;
   logic [TAPW-1:0] sel_q, sel_d;
   logic [TAPW-1:0] tgt_q, tgt_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            ack_q, ack_d;
   logic            busy_q, busy_d;
   logic            clamp_q, clamp_d;

   // State and output registers; reset drops any pending ramp immediately
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         sel_q   <= RST_SEL;
         tgt_q   <= RST_SEL;
         cnt_q   <= 8'd0;
         ack_q   <= 1'b0;
         busy_q  <= 1'b0;
         clamp_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         clamp_q <= clamp_d;
      end
   end

   // Next-state: accept in IDLE, then compare / step / settle until SEL hits target
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      clamp_d = clamp_q;
      case (state_q)
         S_IDLE: begin
            if (REQ) begin
               // Out-of-range targets are clamped so SEL can never wrap
               tgt_d   = (TGT > MAX_TAP) ? MAX_TAP : TGT;
               clamp_d = (TGT > MAX_TAP);
               state_d = S_CMP;
            end
         end
         S_CMP: begin
            state_d = (sel_q == tgt_q) ? S_DONE : S_STEP;
         end
         S_STEP: begin
            sel_d   = (tgt_q > sel_q) ? sel_q + TAPW'(1) : sel_q - TAPW'(1);
            cnt_d   = SETTLE_CNT;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 8'd1;
            // Leaves after exactly SETTLE cycles in WAIT
            if (cnt_q <= 8'd1) state_d = S_CMP;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Registered flags follow the state being entered
      busy_d = (state_d != S_IDLE);
      ack_d  = (state_d == S_DONE);
   end

   assign ACK   = ack_q;
   assign BUSY  = busy_q;
   assign SEL   = sel_q;
   assign CLAMP = clamp_q;

endmodule

// File: tb/tb_scs8hd_dlytap_ctrl.sv
// Bench for scs8hd_dlytap_ctrl: a timing model driven by "cycles since the
// request was accepted" predicts SEL/ACK/BUSY/CLAMP every cycle; directed
// sequences pin the model with hand-computed latencies, then random requests
// (with TGT jitter while busy and occasional mid-ramp resets) follow.
module tb_scs8hd_dlytap_ctrl;
   localparam int NT = 12;
   localparam int TW = 4;
   localparam int ST = 3;
   localparam int S2 = ST + 2;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          REQ = 1'b0;
   logic [TW-1:0] TGT = '0;
   logic          ACK, BUSY, CLAMP;
   logic [TW-1:0] SEL;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   scs8hd_dlytap_ctrl #(.NTAPS(NT), .TAPW(TW), .SETTLE(ST), .RST_TAP(0)) dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .TGT(TGT),
      .ACK(ACK), .BUSY(BUSY), .SEL(SEL), .CLAMP(CLAMP)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // While a request is active, k counts cycles since acceptance (k=0 is the
   // cycle REQ was sampled). The n-th step becomes visible at k = 3+(n-1)*S2,
   // ACK is at k = 2+d*S2, BUSY covers k = 1..2+d*S2.
   bit m_act = 0;
   bit m_clamp = 0;
   int m_k = 0, m_s = 0, m_g = 0, m_d = 0, m_L = 0, m_idle_sel = 0, m_t = 0;

   initial forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
         m_act = 0; m_idle_sel = 0; m_clamp = 0;
      end else begin
         cyc++;
         if (m_act) begin
            m_k++;
            if (m_k > m_L) begin
               m_act = 0;
               m_idle_sel = m_g;
            end
         end else if (REQ) begin
            m_t     = int'(TGT);
            m_act   = 1;
            m_k     = 1;
            m_s     = m_idle_sel;
            m_g     = (m_t > NT - 1) ? NT - 1 : m_t;
            m_clamp = (m_t > NT - 1);
            m_d     = (m_g > m_s) ? m_g - m_s : m_s - m_g;
            m_L     = 2 + m_d * S2;
         end
      end
   end

   function automatic int exp_sel();
      int n;
      if (!m_act) return m_idle_sel;
      n = (m_k >= 3) ? (m_k - 3) / S2 + 1 : 0;
      if (n > m_d) n = m_d;
      return (m_g >= m_s) ? m_s + n : m_s - n;
   endfunction

   // Per-cycle compare against the model
   initial forever begin
      @(negedge CLK);
      if (!RESET && cyc > 0) begin
         chk("sel",   int'(SEL),   exp_sel());
         chk("ack",   int'(ACK),   int'(m_act && m_k == m_L));
         chk("busy",  int'(BUSY),  int'(m_act));
         chk("clamp", int'(CLAMP), int'(m_clamp));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_ack(input bit jitter, output bit got);
      got = 0;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(negedge CLK);
         if (ACK) got = 1;
         else if (jitter) TGT = TW'($urandom_range(0, 15));
      end
      chk("ack_timeout", int'(got), 1);
   endtask

   task automatic do_req(input int t, output int lat);
      int c0;
      bit got;
      @(posedge CLK); #2;
      REQ = 1'b1; TGT = TW'(t); c0 = cyc;
      @(posedge CLK); #2;
      REQ = 1'b0;
      wait_ack(1'b1, got);
      lat = cyc - c0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(posedge CLK);
   endtask

   task automatic mid_reset();
      #2; RESET = 1'b1; #1;
      chk("rst_sel",   int'(SEL),   0);
      chk("rst_ack",   int'(ACK),   0);
      chk("rst_busy",  int'(BUSY),  0);
      chk("rst_clamp", int'(CLAMP), 0);
      @(posedge CLK); #2;
      RESET = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int lat, c0, acks, t, w;
      bit got;

      // Reset values visible before any clock edge
      #1;
      chk("init_sel",   int'(SEL),   0);
      chk("init_ack",   int'(ACK),   0);
      chk("init_busy",  int'(BUSY),  0);
      chk("init_clamp", int'(CLAMP), 0);
      idle_cycles(3); #2;
      RESET = 1'b0;

      // Idle with REQ low; model checks every cycle
      idle_cycles(50);
      @(posedge CLK); #1;
      mid_reset();
      idle_cycles(5);

      // Up-ramp 0->3
      do_req(3, lat);
      chk("lat_0_3", lat, 17);
      chk("sel_0_3", int'(SEL), 3);

      // Same tap
      do_req(3, lat);
      chk("lat_same", lat, 2);
      chk("clamp_same", int'(CLAMP), 0);

      // Move to 9, then clamped request and in-range follow-up
      do_req(9, lat);
      chk("lat_3_9", lat, 32);
      do_req(15, lat);
      chk("lat_clamp", lat, 12);
      chk("sel_clamp", int'(SEL), 11);
      chk("clamp_set", int'(CLAMP), 1);
      do_req(2, lat);
      chk("lat_11_2", lat, 47);
      chk("clamp_clr", int'(CLAMP), 0);
      chk("sel_11_2", int'(SEL), 2);

      // TGT jitters (including to 1) while busy; ramp must still reach 8
      do_req(0, lat);
      chk("lat_2_0", lat, 12);
      do_req(8, lat);
      chk("lat_0_8", lat, 42);
      chk("sel_0_8", int'(SEL), 8);
      do_req(0, lat);
      chk("lat_8_0", lat, 42);

      // Reset mid-ramp on the way to 12 (clamped to 11)
      @(posedge CLK); #2;
      REQ = 1'b1; TGT = TW'(12);
      @(posedge CLK); #2;
      REQ = 1'b0;
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge CLK);
         if (SEL == TW'(5)) got = 1;
      end
      chk("sel5_reached", int'(got), 1);
      chk("clamp_mid", int'(CLAMP), 1);
      mid_reset();
      acks = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (ACK) acks++;
      end
      chk("no_ack_after_rst", acks, 0);

      // Back-to-back: REQ held across ACK
      @(posedge CLK); #2;
      REQ = 1'b1; TGT = TW'(2); c0 = cyc;
      wait_ack(1'b0, got);
      chk("lat_b2b_1", cyc - c0, 12);
      TGT = TW'(4);
      @(negedge CLK);
      chk("b2b_idle_busy", int'(BUSY), 0);
      c0 = cyc;
      @(posedge CLK); #2;
      REQ = 1'b0;
      @(negedge CLK);
      chk("b2b_busy_again", int'(BUSY), 1);
      wait_ack(1'b1, got);
      chk("lat_b2b_2", cyc - c0, 12);
      chk("sel_b2b_2", int'(SEL), 4);

      // Random requests, occasional mid-ramp reset
      for (int n = 0; n < 40; n++) begin
         idle_cycles($urandom_range(0, 4));
         t = $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) begin
            @(posedge CLK); #2;
            REQ = 1'b1; TGT = TW'(t);
            @(posedge CLK); #2;
            REQ = 1'b0;
            w = $urandom_range(1, 30);
            for (int i = 0; i < w; i++) @(negedge CLK);
            mid_reset();
         end else begin
            do_req(t, lat);
            chk("rnd_sel", int'(SEL), (t > NT - 1) ? NT - 1 : t);
            chk("rnd_clamp", int'(CLAMP), int'(t > NT - 1));
         end
      end
      idle_cycles(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard against a hung run
   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
